// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice.
//   owner_t : who issued the read that is currently in flight (or NONE)
//   state_t : arbiter mode, ARB (normal sharing) or LOCKED (debug burst)
//   LED_ADDR: memory-mapped LED register, handy for benches and debug
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

endpackage

// File: rtl/dmem_arb_age.sv
// ---------------------------------------------------------------------------
// dmem_arb_age
// Winner selection between the core (A) and the debug engine (B), plus the
// starvation counter that lets B eventually win against a busy core.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_a_req        : core request
//   i_b_req        : debug request
//   i_locked       : arbiter is in the LOCKED state (only B may win)
//   o_winner       : which requester owns the memory port this cycle
// ---------------------------------------------------------------------------
module dmem_arb_age
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_a_req,
    input  logic   i_b_req,
    input  logic   i_locked,
    output owner_t o_winner
);

    localparam logic [CNT_W-1:0] LIMIT   = STARVE_LIMIT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             w_starved;
    owner_t           w_winner;

    // A has priority on a conflict unless B has waited long enough; while
    // locked the core is shut out completely.
    function automatic owner_t pick_winner(input logic a, input logic b,
                                           input logic lk, input logic starved);
        owner_t w;
        w = OWN_NONE;
        if (lk) begin
            if (b) w = OWN_B;
        end else if (a && b) begin
            w = starved ? OWN_B : OWN_A;
        end else if (a) begin
            w = OWN_A;
        end else if (b) begin
            w = OWN_B;
        end
        return w;
    endfunction

    // A limit of zero turns aging off entirely.
    assign w_starved = (STARVE_LIMIT != 0) && (r_cnt >= LIMIT);

    // Nobody is granted while reset is held, even though the inputs may be live.
    assign w_winner = i_rst_n ? pick_winner(i_a_req, i_b_req, i_locked, w_starved)
                              : OWN_NONE;
    assign o_winner = w_winner;

    // Count cycles B spends waiting; a grant to B forgives everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_winner == OWN_B) begin
            r_cnt <= '0;
        end else if (i_b_req && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data_memory port between the core LSU (A) and the UART
// debug/loader engine (B). Muxes the winner's access onto the memory, steers
// the 1-cycle read data back to whoever issued the read, and supports a
// B-side lock that stalls the core for atomic debug bursts.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_a_* / o_a_*                  : core request, grant, read return
//   i_b_* / o_b_*, i_b_lock        : debug request, grant, read return, lock
//   o_mem_* / i_mem_read_data      : data_memory interface
//   o_locked                       : high while B holds the lock (core stall)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic [3:0]        i_a_sign_mask,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    input  logic [3:0]        i_b_sign_mask,
    input  logic              i_b_lock,
    output logic              o_b_gnt,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_memwrite,
    output logic              o_mem_memread,
    output logic [3:0]        o_mem_sign_mask,
    input  logic [DATA_W-1:0] i_mem_read_data,
    output logic              o_locked
);

    state_t r_state;
    state_t w_state_nxt;
    owner_t r_rd_owner;
    owner_t w_winner;
    logic   w_a_sel;
    logic   w_b_sel;
    logic   w_we;

    dmem_arb_age #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_age (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_a_req  (i_a_req),
        .i_b_req  (i_b_req),
        .i_locked (r_state == ST_LOCKED),
        .o_winner (w_winner)
    );

    assign w_a_sel = (w_winner == OWN_A);
    assign w_b_sel = (w_winner == OWN_B);
    assign o_a_gnt = w_a_sel;
    assign o_b_gnt = w_b_sel;

    // With no winner the address/data lines just show A; only the strobes matter.
    assign o_mem_addr       = w_b_sel ? i_b_addr      : i_a_addr;
    assign o_mem_write_data = w_b_sel ? i_b_wdata     : i_a_wdata;
    assign o_mem_sign_mask  = w_b_sel ? i_b_sign_mask : i_a_sign_mask;
    assign w_we             = w_b_sel ? i_b_we        : i_a_we;
    assign o_mem_memwrite   = (w_a_sel | w_b_sel) &  w_we;
    assign o_mem_memread    = (w_a_sel | w_b_sel) & ~w_we;

    // Mode register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock is taken only on an actual B grant, and released on the first cycle
    // B drops b_lock (that cycle is still arbitrated under LOCKED rules).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:    if (w_b_sel && i_b_lock) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (!i_b_lock)           w_state_nxt = ST_ARB;
            default:   w_state_nxt = ST_ARB;
        endcase
    end

    // Remember who issued the read so next cycle's memory data goes to them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_owner <= OWN_NONE;
        end else if (o_mem_memread) begin
            r_rd_owner <= w_winner;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    assign o_a_rvalid = (r_rd_owner == OWN_A);
    assign o_b_rvalid = (r_rd_owner == OWN_B);
    assign o_a_rdata  = i_mem_read_data;
    assign o_b_rdata  = i_mem_read_data;
    assign o_locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A word-addressed memory stands in for
// data_memory; a behavioural model predicts grants, memory strobes, lock
// state and read returns every cycle, and directed steps pin key values.
// A second instance with aging disabled checks strict A priority.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int LIMIT   = 8;
    localparam int CNT_SAT = 15;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        aReq, aWe, bReq, bWe, bLock;
    logic [31:0] aAddr, aWdata, bAddr, bWdata;
    logic [3:0]  aMask, bMask;
    logic        aGnt, aRvalid, bGnt, bRvalid;
    logic [31:0] aRdata, bRdata;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memWrite, memRead, locked;
    logic [3:0]  memMask;

    logic        sAReq, sBReq;
    logic        sAGnt, sARvalid, sBGnt, sBRvalid, sMemWrite, sMemRead, sLocked;
    logic [31:0] sARdata, sBRdata, sMemAddr, sMemWdata;
    logic [3:0]  sMemMask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_a_req(aReq), .i_a_we(aWe), .i_a_addr(aAddr), .i_a_wdata(aWdata),
        .i_a_sign_mask(aMask), .o_a_gnt(aGnt), .o_a_rvalid(aRvalid), .o_a_rdata(aRdata),
        .i_b_req(bReq), .i_b_we(bWe), .i_b_addr(bAddr), .i_b_wdata(bWdata),
        .i_b_sign_mask(bMask), .i_b_lock(bLock), .o_b_gnt(bGnt), .o_b_rvalid(bRvalid),
        .o_b_rdata(bRdata), .o_mem_addr(memAddr), .o_mem_write_data(memWdata),
        .o_mem_memwrite(memWrite), .o_mem_memread(memRead), .o_mem_sign_mask(memMask),
        .i_mem_read_data(memRdata), .o_locked(locked)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0), .CNT_W(4)) dut0 (
        .i_clk(clk), .i_rst_n(rstN),
        .i_a_req(sAReq), .i_a_we(1'b0), .i_a_addr(32'h4), .i_a_wdata(32'h0),
        .i_a_sign_mask(4'hF), .o_a_gnt(sAGnt), .o_a_rvalid(sARvalid), .o_a_rdata(sARdata),
        .i_b_req(sBReq), .i_b_we(1'b0), .i_b_addr(32'h8), .i_b_wdata(32'h0),
        .i_b_sign_mask(4'hF), .i_b_lock(1'b0), .o_b_gnt(sBGnt), .o_b_rvalid(sBRvalid),
        .o_b_rdata(sBRdata), .o_mem_addr(sMemAddr), .o_mem_write_data(sMemWdata),
        .o_mem_memwrite(sMemWrite), .o_mem_memread(sMemRead), .o_mem_sign_mask(sMemMask),
        .i_mem_read_data(32'h0), .o_locked(sLocked)
    );

    // Stand-in for data_memory: write at the edge, registered read data.
    logic [31:0] envMem [logic [31:0]];
    always @(posedge clk) begin
        if (memWrite) envMem[memAddr] = memWdata;
        if (memRead) memRdata <= envMem.exists(memAddr) ? envMem[memAddr] : 32'h0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Behavioural model: 0 = nobody, 1 = A, 2 = B.
    int          mCnt = 0;
    bit          mLocked = 0;
    int          mRdOwner = 0;
    logic [31:0] mRdData = 32'h0;
    logic [31:0] shadow [logic [31:0]];
    int          expWin = 0;

    // Predict this cycle's outcome and compare every observable output.
    always @(negedge clk) begin
        logic        selWe;
        logic [31:0] selAddr, selData;
        logic [3:0]  selMask;
        if (!rstN) begin
            mCnt = 0; mLocked = 0; mRdOwner = 0;
        end
        expWin = 0;
        if (rstN) begin
            if (mLocked) expWin = bReq ? 2 : 0;
            else if (aReq && bReq) expWin = (LIMIT != 0 && mCnt >= LIMIT) ? 2 : 1;
            else if (aReq) expWin = 1;
            else if (bReq) expWin = 2;
        end
        selWe   = (expWin == 2) ? bWe   : aWe;
        selAddr = (expWin == 2) ? bAddr : aAddr;
        selData = (expWin == 2) ? bWdata : aWdata;
        selMask = (expWin == 2) ? bMask : aMask;
        checkBit("a_gnt", aGnt, expWin == 1);
        checkBit("b_gnt", bGnt, expWin == 2);
        checkBit("mem_memwrite", memWrite, expWin != 0 && selWe);
        checkBit("mem_memread", memRead, expWin != 0 && !selWe);
        checkBit("locked", locked, mLocked);
        checkBit("a_rvalid", aRvalid, mRdOwner == 1);
        checkBit("b_rvalid", bRvalid, mRdOwner == 2);
        if (expWin != 0) begin
            checkOutput("mem_addr", memAddr, selAddr);
            checkOutput("mem_sign_mask", {28'b0, memMask}, {28'b0, selMask});
            if (selWe) checkOutput("mem_write_data", memWdata, selData);
        end
        if (mRdOwner == 1) checkOutput("a_rdata", aRdata, mRdData);
        if (mRdOwner == 2) checkOutput("b_rdata", bRdata, mRdData);
    end

    // Advance the model across the clock edge.
    always @(posedge clk) begin
        logic [31:0] addr;
        if (!rstN) begin
            mCnt = 0; mLocked = 0; mRdOwner = 0;
        end else begin
            addr = (expWin == 2) ? bAddr : aAddr;
            mRdOwner = 0;
            if (expWin != 0) begin
                if ((expWin == 2) ? bWe : aWe) begin
                    shadow[addr] = (expWin == 2) ? bWdata : aWdata;
                end else begin
                    mRdOwner = expWin;
                    mRdData = shadow.exists(addr) ? shadow[addr] : 32'h0;
                end
            end
            if (expWin == 2) mCnt = 0;
            else if (bReq && mCnt < CNT_SAT) mCnt++;
            if (!mLocked) begin
                if (expWin == 2 && bLock) mLocked = 1;
            end else if (!bLock) begin
                mLocked = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ar, input logic aw, input logic [31:0] aa,
                                 input logic [31:0] ad, input logic br, input logic bw,
                                 input logic bl, input logic [31:0] ba, input logic [31:0] bd);
        aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
        bReq = br; bWe = bw; bLock = bl; bAddr = ba; bWdata = bd;
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        aMask = 4'hF; bMask = 4'h3;
        sAReq = 1'b0; sBReq = 1'b0;
        // Requests live during reset: nothing may be granted or strobed.
        applyStimulus(1, 0, 32'h5, 0, 1, 0, 0, 32'h9, 0);
        @(negedge clk);
        checkBit("rst_a_gnt", aGnt, 1'b0);
        checkBit("rst_b_gnt", bGnt, 1'b0);
        checkBit("rst_memread", memRead, 1'b0);
        checkBit("rst_locked", locked, 1'b0);
        checkOutput("rst_cnt", 32'(dut.u_age.r_cnt), 32'd0);
        tick();
        rstN = 1'b1;

        // Single A write then read.
        applyStimulus(1, 1, 32'h5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        @(negedge clk); checkBit("t1_wr_gnt", aGnt, 1'b1); tick();
        applyStimulus(1, 0, 32'h5, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkBit("t1_rd_gnt", aGnt, 1'b1); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkBit("t1_a_rvalid", aRvalid, 1'b1);
        checkOutput("t1_a_rdata", aRdata, 32'hDEADBEEF);
        checkBit("t1_b_rvalid", bRvalid, 1'b0);
        tick();

        // Alternating-owner reads.
        applyStimulus(1, 1, 32'h1, 32'h11, 0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h2, 32'h22); tick();
        applyStimulus(1, 0, 32'h1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkBit("t3_a_gnt", aGnt, 1'b1); tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h2, 0);
        @(negedge clk);
        checkBit("t3_b_gnt", bGnt, 1'b1);
        checkBit("t3_a_rvalid", aRvalid, 1'b1);
        checkOutput("t3_a_rdata", aRdata, 32'h11);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkBit("t3_b_rvalid", bRvalid, 1'b1);
        checkOutput("t3_b_rdata", bRdata, 32'h22);
        checkBit("t3_a_rvalid_off", aRvalid, 1'b0);
        tick();

        // Continuous conflict: B must win exactly on cycle 8.
        applyStimulus(1, 0, 32'h1, 0, 1, 0, 0, 32'h2, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkBit($sformatf("t2_a_gnt_c%0d", i), aGnt, i != 8);
            checkBit($sformatf("t2_b_gnt_c%0d", i), bGnt, i == 8);
            if (i == 8) checkOutput("t2_cnt_at_win", 32'(dut.u_age.r_cnt), 32'd8);
            if (i == 9) checkOutput("t2_cnt_cleared", 32'(dut.u_age.r_cnt), 32'd0);
            tick();
        end

        // Locked burst to the LED region while the core keeps asking.
        applyStimulus(0, 0, 0, 0, 1, 1, 1, LED_ADDR, 32'h000000A5);
        @(negedge clk);
        checkBit("t4_first_b_gnt", bGnt, 1'b1);
        checkBit("t4_first_locked", locked, 1'b0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 0, 32'h1, 0, 1, 1, 1, LED_ADDR + 32'(4 * k), 32'(k));
            @(negedge clk);
            checkBit($sformatf("t4_locked_%0d", k), locked, 1'b1);
            checkBit($sformatf("t4_a_gnt_%0d", k), aGnt, 1'b0);
            tick();
        end
        applyStimulus(1, 0, 32'h1, 0, 1, 0, 1, LED_ADDR, 0);
        @(negedge clk); checkBit("t4_led_rd_gnt", bGnt, 1'b1); tick();
        applyStimulus(1, 0, 32'h1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkBit("t4_unlock_cycle_locked", locked, 1'b1);
        checkBit("t4_unlock_cycle_a_gnt", aGnt, 1'b0);
        checkBit("t4_led_rvalid", bRvalid, 1'b1);
        checkOutput("t4_led_rdata", bRdata, 32'h000000A5);
        tick();
        @(negedge clk);
        checkBit("t4_after_locked", locked, 1'b0);
        checkBit("t4_after_a_gnt", aGnt, 1'b1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t4_a_rdata", aRdata, 32'h11); tick();

        // Reset right after a granted, locking B read.
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h2, 0);
        @(negedge clk); checkBit("t5_b_gnt", bGnt, 1'b1); tick();
        rstN = 1'b0;
        applyStimulus(1, 0, 32'h1, 0, 1, 0, 1, 32'h2, 0);
        @(negedge clk);
        checkBit("t5_b_rvalid", bRvalid, 1'b0);
        checkBit("t5_locked", locked, 1'b0);
        checkBit("t5_a_gnt", aGnt, 1'b0);
        checkBit("t5_b_gnt", bGnt, 1'b0);
        checkOutput("t5_cnt", 32'(dut.u_age.r_cnt), 32'd0);
        tick();
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkBit("t5_no_spurious_b", bRvalid, 1'b0);
        checkBit("t5_no_spurious_a", aRvalid, 1'b0);
        tick();

        // Aging disabled: A always wins, counter saturates.
        sAReq = 1'b1; sBReq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkBit($sformatf("t6_a_gnt_c%0d", i), sAGnt, 1'b1);
            checkBit($sformatf("t6_b_gnt_c%0d", i), sBGnt, 1'b0);
            tick();
        end
        @(negedge clk);
        checkOutput("t6_cnt_sat", 32'(dut0.u_age.r_cnt), 32'd15);
        sAReq = 1'b0; sBReq = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
